// File: rtl/coin_pkg.sv
// Shared coin values, default credit ceiling and acceptor state encoding.
package coin_pkg;
  localparam int COIN5_VAL          = 5;
  localparam int COIN10_VAL         = 10;
  localparam int CREDIT_MAX_DEFAULT = 20;
  localparam int BAL_W              = 5;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_REFUND = 1'b1
  } state_t;

  // Value of a coin, one bit wider than balance so sums up to 40 never wrap.
  function automatic logic [BAL_W:0] coin_value(input logic is10);
    return is10 ? (BAL_W+1)'(COIN10_VAL) : (BAL_W+1)'(COIN5_VAL);
  endfunction
endpackage

// File: rtl/coin_debounce.sv
// Coin sensor debouncer: one accept pulse per stable-high period, re-armed after a stable-low period.
module coin_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sense,
  output logic accept
);
  localparam logic [3:0] LAST = 4'(DEBOUNCE_CYCLES - 1);

  logic [3:0] cnt_reg;
  logic       fired_reg;
  logic       accept_reg;

  // The counter tracks consecutive samples that disagree with fired_reg;
  // reaching DEBOUNCE_CYCLES flips the flag, and a low->high flip emits the pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_reg    <= '0;
      fired_reg  <= 1'b0;
      accept_reg <= 1'b0;
    end else begin
      accept_reg <= 1'b0;
      if (sense == fired_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == LAST) begin
        cnt_reg    <= '0;
        fired_reg  <= ~fired_reg;
        accept_reg <= ~fired_reg;
      end else begin
        cnt_reg <= cnt_reg + 4'd1;
      end
    end
  end

  assign accept = accept_reg;
endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: debounced 5/10 sensors, credit/refund FSM with balance tracking.
// Define COIN_ACCEPTOR_SYNC_EN to add 2-flop input synchronizers ahead of the debouncers.
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CREDIT_MAX      = CREDIT_MAX_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             coin5_raw,
  input  logic             coin10_raw,
  input  logic             vend_done,
  input  logic             cancel,
  output logic             credit5,
  output logic             credit10,
  output logic             coin_reject,
  output logic             refund5,
  output logic [BAL_W-1:0] balance,
  output logic             busy
);
  // Bit 0 is the 5-unit sensor, bit 1 the 10-unit sensor.
  logic [1:0] raw_vec;
  logic [1:0] sense_vec;
  logic [1:0] accept_vec;

  assign raw_vec = {coin10_raw, coin5_raw};

`ifdef COIN_ACCEPTOR_SYNC_EN
  logic [1:0] sync1_reg;
  logic [1:0] sync2_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= raw_vec;
      sync2_reg <= sync1_reg;
    end
  end

  assign sense_vec = sync2_reg;
`else
  assign sense_vec = raw_vec;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_deb
      coin_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
        .clk    (clk),
        .rst    (rst),
        .sense  (sense_vec[gi]),
        .accept (accept_vec[gi])
      );
    end
  endgenerate

  state_t           state_reg;
  logic [BAL_W-1:0] balance_reg;
  logic             pend5_reg;
  logic             pend5_next;
  logic             gap_reg;
  logic             credit5_reg;
  logic             credit10_reg;
  logic             reject_reg;
  logic             refund5_reg;

  logic             coin_valid;
  logic             coin_is10;
  logic             coin_fits;
  logic [BAL_W:0]   base_bal;
  logic [BAL_W:0]   sum_bal;
  logic [BAL_W:0]   coin_bal;

  // One coin per cycle: a 10 always goes first, a simultaneous 5 waits one cycle.
  always_comb begin
    coin_valid = accept_vec[1] | accept_vec[0] | pend5_reg;
    coin_is10  = accept_vec[1];
    pend5_next = pend5_reg ? (accept_vec[1] | accept_vec[0])
                           : (accept_vec[1] & accept_vec[0]);
    base_bal   = (state_reg == ST_IDLE && vend_done) ? '0 : {1'b0, balance_reg};
    sum_bal    = base_bal + coin_value(coin_is10);
    coin_fits  = (state_reg == ST_IDLE) && (sum_bal <= (BAL_W+1)'(CREDIT_MAX));
    coin_bal   = (coin_valid && coin_fits) ? sum_bal : base_bal;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      balance_reg  <= '0;
      pend5_reg    <= 1'b0;
      gap_reg      <= 1'b0;
      credit5_reg  <= 1'b0;
      credit10_reg <= 1'b0;
      reject_reg   <= 1'b0;
      refund5_reg  <= 1'b0;
    end else begin
      pend5_reg    <= pend5_next;
      credit5_reg  <= coin_valid && coin_fits && !coin_is10;
      credit10_reg <= coin_valid && coin_fits && coin_is10;
      reject_reg   <= coin_valid && !coin_fits;
      refund5_reg  <= 1'b0;
      if (state_reg == ST_IDLE) begin
        balance_reg <= coin_bal[BAL_W-1:0];
        gap_reg     <= 1'b0;
        if (cancel && coin_bal != '0) begin
          state_reg <= ST_REFUND;
        end
      end else begin
        // Refund pulses alternate with gap cycles; leave one cycle after the last.
        if (balance_reg == '0) begin
          state_reg <= ST_IDLE;
        end else if (!gap_reg) begin
          refund5_reg <= 1'b1;
          balance_reg <= balance_reg - BAL_W'(COIN5_VAL);
          gap_reg     <= 1'b1;
        end else begin
          gap_reg <= 1'b0;
        end
      end
    end
  end

  assign credit5     = credit5_reg;
  assign credit10    = credit10_reg;
  assign coin_reject = reject_reg;
  assign refund5     = refund5_reg;
  assign balance     = balance_reg;
  assign busy        = (state_reg == ST_REFUND);
endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench for coin_acceptor: directed scenarios plus randomized coin/cancel/vend traffic.
module tb_coin_acceptor;
  localparam int N    = 4;
  localparam int CMAX = 20;
`ifdef COIN_ACCEPTOR_SYNC_EN
  localparam int LAT = N + 3;
`else
  localparam int LAT = N + 1;
`endif
  // Event kinds carried by the scoreboard.
  localparam int EV_C5 = 0, EV_C10 = 1, EV_REJ = 2, EV_REF = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic coin5_raw = 1'b0, coin10_raw = 1'b0, vend_done = 1'b0, cancel = 1'b0;
  logic credit5, credit10, coin_reject, refund5, busy;
  logic [4:0] balance;

  coin_acceptor #(.DEBOUNCE_CYCLES(N), .CREDIT_MAX(CMAX)) dut (
    .clk(clk), .rst(rst), .coin5_raw(coin5_raw), .coin10_raw(coin10_raw),
    .vend_done(vend_done), .cancel(cancel), .credit5(credit5), .credit10(credit10),
    .coin_reject(coin_reject), .refund5(refund5), .balance(balance), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int kind; int bal;} exp_t;
  exp_t sb[$];

  int checks = 0, errors = 0;
  int cyc = 0;
  int last_ev_cyc = 0, last_refund_cyc = -100, c10_cyc = 0, c5_cyc = 0;
  int model_bal = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every pulse cycle pops one expected event and compares kind and balance.
  always @(negedge clk) begin
    int nh, kind;
    exp_t e;
    if (rst) begin
      nh = int'(credit5) + int'(credit10) + int'(coin_reject) + int'(refund5);
      if (nh > 0) begin
        last_ev_cyc = cyc;
        checks++;
        if (nh > 1) begin
          errors++;
          $display("FAIL one_hot: %0d pulses high at cycle %0d, required 1", nh, cyc);
        end
        kind = credit5 ? EV_C5 : credit10 ? EV_C10 : coin_reject ? EV_REJ : EV_REF;
        if (kind == EV_C10) c10_cyc = cyc;
        if (kind == EV_C5) c5_cyc = cyc;
        if (kind == EV_REF) begin
          if (cyc - last_refund_cyc <= 4) begin
            checks++;
            if (cyc - last_refund_cyc != 2) begin
              errors++;
              $display("FAIL refund_spacing: gap %0d cycles, required 2", cyc - last_refund_cyc);
            end
          end
          last_refund_cyc = cyc;
        end
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: kind %0d bal %0d at cycle %0d, none expected", kind, balance, cyc);
        end else begin
          e = sb.pop_front();
          if (kind != e.kind || int'(balance) != e.bal) begin
            errors++;
            $display("FAIL event: got kind %0d bal %0d, required kind %0d bal %0d",
                     kind, balance, e.kind, e.bal);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic drain(input string name, input int budget);
    int b;
    b = budget;
    while (sb.size() != 0 && b > 0) begin
      @(negedge clk);
      b--;
    end
    chk({name, "_pending"}, sb.size(), 0);
    sb.delete();
  endtask

  // Reference model: coin accepted only in IDLE and only if it fits under the ceiling.
  function automatic void model_coin(input int v, input bit refunding);
    exp_t e;
    if (!refunding && model_bal + v <= CMAX) begin
      model_bal += v;
      e.kind = (v == 5) ? EV_C5 : EV_C10;
    end else begin
      e.kind = EV_REJ;
    end
    e.bal = model_bal;
    sb.push_back(e);
  endfunction

  function automatic void model_refund_all();
    exp_t e;
    while (model_bal > 0) begin
      model_bal -= 5;
      e.kind = EV_REF;
      e.bal  = model_bal;
      sb.push_back(e);
    end
  endfunction

  task automatic set_raw(input int which, input logic v);
    if (which != 1) coin5_raw = v;
    if (which != 0) coin10_raw = v;
  endtask

  // which: 0 = 5-unit, 1 = 10-unit, 2 = both together; includes glitches and bounce.
  task automatic insert(input int which);
    if (which == 0) model_coin(5, 1'b0);
    else if (which == 1) model_coin(10, 1'b0);
    else begin
      model_coin(10, 1'b0);
      model_coin(5, 1'b0);
    end
    if ($urandom_range(0, 1) == 1) begin
      set_raw(which, 1'b1);
      tick($urandom_range(1, N - 1));
      set_raw(which, 1'b0);
      tick($urandom_range(1, 3));
    end
    set_raw(which, 1'b1);
    tick(N + 2);
    if ($urandom_range(0, 1) == 1) begin
      set_raw(which, 1'b0);
      tick($urandom_range(1, N - 1));
      set_raw(which, 1'b1);
      tick(3);
    end
    set_raw(which, 1'b0);
    drain("insert", 20);
    tick(2 * N + 6);
    chk("insert_balance", int'(balance), model_bal);
  endtask

  task automatic do_cancel();
    model_refund_all();
    cancel = 1'b1;
    tick(1);
    cancel = 1'b0;
    drain("cancel", 40);
    tick(4);
    chk("cancel_busy", int'(busy), 0);
    chk("cancel_balance", int'(balance), model_bal);
  endtask

  task automatic do_vend();
    model_bal = 0;
    vend_done = 1'b1;
    tick(1);
    vend_done = 1'b0;
    tick(3);
    chk("vend_balance", int'(balance), 0);
  endtask

  initial begin
    int start, r;
    exp_t e;

    // Reset state
    tick(3);
    chk("rst_credit5", int'(credit5), 0);
    chk("rst_credit10", int'(credit10), 0);
    chk("rst_reject", int'(coin_reject), 0);
    chk("rst_refund5", int'(refund5), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_balance", int'(balance), 0);
    rst = 1'b1;
    tick(2);

    // Single coin5 held 10 cycles: one credit5 at the fixed latency
    model_coin(5, 1'b0);
    start = cyc;
    coin5_raw = 1'b1;
    tick(10);
    coin5_raw = 1'b0;
    drain("hold5", 20);
    chk("hold5_latency", last_ev_cyc - start, LAT);
    tick(2 * N + 4);
    chk("hold5_balance", int'(balance), 5);
    $display("txn directed hold5 bal=%0d", balance);

    // 3-cycle glitch on coin10: no event
    coin10_raw = 1'b1;
    tick(3);
    coin10_raw = 1'b0;
    tick(LAT + 6);
    chk("glitch_balance", int'(balance), 5);
    $display("txn directed glitch10 bal=%0d", balance);

    // 10, 10, 5 from zero: credit, credit, reject at 20
    do_vend();
    insert(1);
    insert(1);
    insert(0);
    chk("fill_balance", int'(balance), 20);
    $display("txn directed 10/10/5 bal=%0d", balance);

    // Vend at 20: cleared, no refund
    do_vend();
    tick(8);
    $display("txn directed vend bal=%0d", balance);

    // Both sensors in the same cycle: 10 first, 5 on the next cycle
    model_coin(10, 1'b0);
    model_coin(5, 1'b0);
    coin5_raw = 1'b1;
    coin10_raw = 1'b1;
    tick(N + 3);
    coin5_raw = 1'b0;
    coin10_raw = 1'b0;
    drain("both", 20);
    chk("both_order", c5_cyc - c10_cyc, 1);
    tick(2 * N + 4);
    chk("both_balance", int'(balance), 15);
    $display("txn directed both bal=%0d", balance);

    // Cancel at 15 with a coin landing on the first gap cycle of REFUND
    e.kind = EV_REF; e.bal = 10; sb.push_back(e);
    e.kind = EV_REJ; e.bal = 10; sb.push_back(e);
    e.kind = EV_REF; e.bal = 5;  sb.push_back(e);
    e.kind = EV_REF; e.bal = 0;  sb.push_back(e);
    model_bal = 0;
    coin5_raw = 1'b1;
    tick(LAT - 3);
    cancel = 1'b1;
    tick(1);
    cancel = 1'b0;
    chk("refund_busy", int'(busy), 1);
    drain("refund", 30);
    coin5_raw = 1'b0;
    tick(2 * N + 8);
    chk("refund_done_busy", int'(busy), 0);
    chk("refund_done_balance", int'(balance), 0);
    $display("txn directed cancel15 bal=%0d", balance);

    // Reset in the middle of REFUND: everything forfeited
    insert(1);
    insert(1);
    e.kind = EV_REF; e.bal = 15; sb.push_back(e);
    cancel = 1'b1;
    tick(1);
    cancel = 1'b0;
    drain("pre_rst_refund", 10);
    rst = 1'b0;
    tick(1);
    chk("midrst_refund5", int'(refund5), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_balance", int'(balance), 0);
    chk("midrst_credit", int'(credit5) + int'(credit10) + int'(coin_reject), 0);
    model_bal = 0;
    // Sensor already high while reset is released
    coin5_raw = 1'b1;
    tick(2);
    model_coin(5, 1'b0);
    rst = 1'b1;
    start = cyc;
    tick(N + 4);
    coin5_raw = 1'b0;
    drain("rst_release", 20);
    chk("rst_release_latency", last_ev_cyc - start, LAT);
    tick(2 * N + 6);
    chk("rst_release_balance", int'(balance), 5);
    $display("txn directed reset_midrefund bal=%0d", balance);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 2) insert(0);
      else if (r <= 5) insert(1);
      else if (r == 6) insert(2);
      else if (r == 7) begin
        set_raw($urandom_range(0, 1), 1'b1);
        tick($urandom_range(1, N - 1));
        coin5_raw = 1'b0;
        coin10_raw = 1'b0;
        tick(LAT + 6);
        chk("rand_glitch_balance", int'(balance), model_bal);
      end
      else if (r == 8) do_cancel();
      else do_vend();
      $display("txn rand %0d type=%0d bal=%0d model=%0d", i, r, balance, model_bal);
    end

    tick(10);
    chk("final_queue", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/coin_acceptor.md
COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning consecutive stable samples required to accept or release a coin (range 2..15).
REQ-002 SHALL have parameter CREDIT_MAX, default 20, meaning maximum accepted balance in credit units (multiple of 5, at most 30).
REQ-003 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-005 SHALL have port coin5_raw, input, 1, 5-unit coin sensor level (bouncy).
REQ-006 SHALL have port coin10_raw, input, 1, 10-unit coin sensor level (bouncy).
REQ-007 SHALL have port vend_done, input, 1, one-cycle pulse meaning the drink was dispensed and the balance is consumed.
REQ-008 SHALL have port cancel, input, 1, one-cycle refund request.
REQ-009 SHALL have port credit5, output, 1, one-cycle pulse reporting an accepted 5-unit coin to the vending FSM.
REQ-010 SHALL have port credit10, output, 1, one-cycle pulse reporting an accepted 10-unit coin.
REQ-011 SHALL have port coin_reject, output, 1, one-cycle pulse, coin diverted to the return chute.
REQ-012 SHALL have port refund5, output, 1, one-cycle pulse, eject one 5-unit coin.
REQ-013 SHALL have port balance, output, 5, current accepted credit.
REQ-014 SHALL have port busy, output, 1, high while in REFUND.

Function
REQ-015 SHALL accept a coin when its sampled sensor has been high for DEBOUNCE_CYCLES consecutive cycles.
REQ-016 SHALL not re-arm that sensor until it has been low for DEBOUNCE_CYCLES consecutive cycles; a sensor held high yields exactly one event.
REQ-017 SHALL treat any glitch shorter than DEBOUNCE_CYCLES as no event.
REQ-018 SHALL have latency DEBOUNCE_CYCLES+1 cycles without synchronizers, measured from the first edge sampling raw high to the first edge on which the output pulse is high.
REQ-019 SHALL, if balance plus coin value is at most CREDIT_MAX and state is IDLE, pulse the matching credit output once and add the value to balance in the same cycle.
REQ-020 SHALL, if balance plus coin value exceeds CREDIT_MAX or state is REFUND, pulse coin_reject once and leave balance unchanged.
REQ-021 SHALL never assert more than one of credit5, credit10 and coin_reject in the same cycle.
REQ-022 SHALL, when both coins are accepted in the same cycle, process coin10 first and coin5 on the next cycle through a one-deep pending flag.
REQ-023 SHALL implement states IDLE and REFUND.
REQ-024 SHALL move IDLE -> REFUND on cancel when balance > 0; cancel with balance 0 is ignored.
REQ-025 SHALL, in REFUND, assert refund5 on alternate cycles (pulse, gap, pulse, ...), subtracting 5 from balance per pulse.
REQ-026 SHALL return REFUND -> IDLE on the cycle after balance reaches 0.
REQ-027 SHALL, on vend_done in IDLE, clear balance to 0 with no refund; vend_done in REFUND is ignored.
REQ-028 SHALL give precedence to vend_done over a coin acceptance in the same cycle (balance 0, then add coin); cancel and coin together: coin processed first, then REFUND.
REQ-029 SHALL keep balance always in 0..CREDIT_MAX, never wrapping.

Reset
REQ-030 SHALL, while rst is low at a clock edge, force state IDLE and balance 0, and drive all pulse outputs and busy 0.
REQ-031 SHALL, while rst is low at a clock edge, clear the debounce counters, armed flags, pending flag and synchronizers.
REQ-032 SHALL, on reset mid-REFUND, forfeit the remaining balance with no further refund5.
REQ-033 SHALL, when reset is released with a sensor already high, need DEBOUNCE_CYCLES samples before accepting.

Configuration
REQ-034 SHALL, with COIN_ACCEPTOR_SYNC_EN defined, pass coin5_raw and coin10_raw through 2-flop synchronizers before debounce, making latency DEBOUNCE_CYCLES+3.
REQ-035 SHALL, without COIN_ACCEPTOR_SYNC_EN, feed the raw inputs directly to debounce; all other behaviour is identical.

Structure
REQ-036 SHALL place coin values (5, 10), default CREDIT_MAX and the state encoding in shared package coin_pkg.
REQ-037 SHALL implement debounce as sub-module coin_debounce (counter, armed flag, one-cycle accept pulse), instantiated once per sensor.

Verification
REQ-038 SHALL check: N=4, no sync, coin5_raw high 10 cycles -> single credit5 at latency 5, balance 5.
REQ-039 SHALL check: coin10_raw 3-cycle glitch -> no pulse, balance unchanged.
REQ-040 SHALL check: coins 10, 10, then 5 -> credit10, credit10, coin_reject; balance 20.
REQ-041 SHALL check: both sensors accepted the same cycle at balance 0 -> credit10, then credit5 next cycle; balance 15.
REQ-042 SHALL check: balance 15, cancel -> 3 refund5 pulses on alternate cycles, a coin during REFUND gets coin_reject, balance 0, IDLE.
REQ-043 SHALL check: balance 20, vend_done -> balance 0 with no refund5; rst low mid-REFUND -> all outputs 0 next cycle.
